snake_game_ctrl: RTL and testbench

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

---
 rtl/snake_pkg.sv | 25 ++
 rtl/snake_tick_gen.sv | 35 +++
 rtl/snake_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and constants for the snake game controller.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DIE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam int INIT_LEN = 3;

    // Opposite directions differ only in the low bit of the encoding.
    function automatic dir_e dir_opposite(input dir_e d);
        return dir_e'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Period counter: strobe is high during the cycle in which the counter wraps.
module snake_tick_gen #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             strobe
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // >= keeps the counter bounded if the period shrinks below the count.
    assign strobe = enable && (cnt_q >= (period - 1'b1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || strobe) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control FSM: start/pause/die sequencing, step strobe, direction, length and score.
// Optional build macro SNAKE_SPEEDUP_EN shortens the step period as the snake grows.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int MAX_LEN     = 32,
    parameter int DIE_FLASHES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_start,
    input  logic       add_cube,
    input  logic       hit_wall,
    input  logic       hit_body,
    output logic [1:0] game_state,
    output logic       move_tick,
    output logic [1:0] dir,
    output logic [5:0] snake_len,
    output logic [7:0] score,
    output logic       flash_en
);

    localparam int         CNT_W   = $clog2(TICK_CYCLES + 1);
    localparam int         FL_W    = $clog2(DIE_FLASHES + 1);
    localparam logic [5:0] LEN_SAT = 6'(MAX_LEN);
    localparam logic [5:0] LEN_INI = 6'(INIT_LEN);

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d, pend_q, pend_d, key_dir;
    logic              key_vld, hit, move_tick_q, move_tick_d;
    logic              flash_q, flash_d, play_strobe, die_strobe;
    logic [5:0]        len_q, len_d;
    logic [7:0]        score_q, score_d;
    logic [FL_W-1:0]   flcnt_q, flcnt_d;
    logic [CNT_W-1:0]  play_period;

    assign hit = hit_wall | hit_body;

    // Pausing or dying freezes the step counter in the very cycle of the event.
    snake_tick_gen #(.CNT_W(CNT_W)) u_play_tick (
        .clk    (clk),
        .rst    (rst),
        .enable ((state_q == ST_PLAY) && !key_start && !hit),
        .clr    (state_q == ST_IDLE),
        .period (play_period),
        .strobe (play_strobe)
    );

    snake_tick_gen #(.CNT_W(CNT_W)) u_die_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == ST_DIE),
        .clr    (state_q != ST_DIE),
        .period (CNT_W'(TICK_CYCLES)),
        .strobe (die_strobe)
    );

`ifdef SNAKE_SPEEDUP_EN
    logic [CNT_W-1:0] period_q, period_d;

    always_comb begin
        int p;
        p = TICK_CYCLES - (int'(len_q) - INIT_LEN) * (TICK_CYCLES / 16);
        if (p < TICK_CYCLES / 4) begin
            p = TICK_CYCLES / 4;
        end
        period_d = period_q;
        if (state_q == ST_IDLE) begin
            period_d = CNT_W'(TICK_CYCLES);
        end else if (play_strobe) begin
            period_d = CNT_W'(p);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= CNT_W'(TICK_CYCLES);
        end else begin
            period_q <= period_d;
        end
    end

    assign play_period = period_q;
`else
    assign play_period = CNT_W'(TICK_CYCLES);
`endif

    always_comb begin
        key_vld = 1'b1;
        key_dir = DIR_UP;
        if (key_up)         key_dir = DIR_UP;
        else if (key_down)  key_dir = DIR_DOWN;
        else if (key_left)  key_dir = DIR_LEFT;
        else if (key_right) key_dir = DIR_RIGHT;
        else                key_vld = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        len_d       = len_q;
        score_d     = score_q;
        flash_d     = flash_q;
        flcnt_d     = flcnt_q;
        move_tick_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                flash_d = 1'b0;
                if (key_start) begin
                    state_d = ST_PLAY;
                    len_d   = LEN_INI;
                    score_d = 8'd0;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                end
            end
            ST_PLAY: begin
                if (hit) begin
                    state_d = ST_DIE;
                    flcnt_d = '0;
                    flash_d = 1'b0;
                end else begin
                    move_tick_d = play_strobe;
                    if (play_strobe) dir_d = pend_q;
                    if (key_vld && (key_dir != dir_opposite(dir_q))) pend_d = key_dir;
                    if (add_cube) begin
                        if (len_q < LEN_SAT)  len_d   = len_q + 6'd1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end
                    if (key_start) state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (key_start) state_d = ST_PLAY;
            end
            ST_DIE: begin
                if (die_strobe) begin
                    flash_d = ~flash_q;
                    if (flcnt_q == FL_W'(DIE_FLASHES - 1)) begin
                        state_d = ST_IDLE;
                        flash_d = 1'b0;
                        flcnt_d = '0;
                    end else begin
                        flcnt_d = flcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            len_q       <= LEN_INI;
            score_q     <= 8'd0;
            flash_q     <= 1'b0;
            flcnt_q     <= '0;
            move_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            len_q       <= len_d;
            score_q     <= score_d;
            flash_q     <= flash_d;
            flcnt_q     <= flcnt_d;
            move_tick_q <= move_tick_d;
        end
    end

    assign game_state = state_q;
    assign move_tick  = move_tick_q;
    assign dir        = dir_q;
    assign snake_len  = len_q;
    assign score      = score_q;
    assign flash_en   = flash_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_CYCLES=10, MAX_LEN=5, DIE_FLASHES=2.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       key_start = 1'b0, add_cube = 1'b0, hit_wall = 1'b0, hit_body = 1'b0;
    logic [1:0] game_state, dir;
    logic       move_tick, flash_en;
    logic [5:0] snake_len;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .TICK_CYCLES (10),
        .MAX_LEN     (5),
        .DIE_FLASHES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_start  (key_start),
        .add_cube   (add_cube),
        .hit_wall   (hit_wall),
        .hit_body   (hit_body),
        .game_state (game_state),
        .move_tick  (move_tick),
        .dir        (dir),
        .snake_len  (snake_len),
        .score      (score),
        .flash_en   (flash_en)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 25 && !seen; i++) begin
            step();
            if (move_tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL sync_tick got no move_tick want move_tick within 25 cycles");
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        checks++;
        if (game_state !== 2'd0 || move_tick !== 1'b0 || dir !== 2'd3 ||
            snake_len !== 6'd3 || score !== 8'd0 || flash_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got st=%0d mt=%0d dir=%0d len=%0d score=%0d fl=%0d want 0 0 3 3 0 0",
                     game_state, move_tick, dir, snake_len, score, flash_en);
        end
        step();
        step();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (game_state !== 2'd0 || flash_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got st=%0d fl=%0d want 0 0", game_state, flash_en);
        end
    endtask

    task automatic test_start_ticks();
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        checks++;
        if (game_state !== 2'd1 || snake_len !== 6'd3 || score !== 8'd0 || dir !== 2'd3) begin
            errors++;
            $display("FAIL start_load got st=%0d len=%0d score=%0d dir=%0d want 1 3 0 3",
                     game_state, snake_len, score, dir);
        end
        for (int c = 1; c <= 35; c++) begin
            step();
            checks++;
            if (move_tick !== ((c % 10) == 0)) begin
                errors++;
                $display("FAIL tick_cycle_%0d got %0d want %0d", c, move_tick, ((c % 10) == 0));
            end
        end
        checks++;
        if (game_state !== 2'd1 || flash_en !== 1'b0) begin
            errors++;
            $display("FAIL play_after_35 got st=%0d fl=%0d want 1 0", game_state, flash_en);
        end
    endtask

    task automatic test_dir_change();
        sync_tick();
        key_left = 1'b1;
        step();
        key_left = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            step();
            checks++;
            if (dir !== 2'd3 || move_tick !== (i == 10)) begin
                errors++;
                $display("FAIL opposite_dropped_%0d got dir=%0d mt=%0d want dir=3 mt=%0d",
                         i, dir, move_tick, (i == 10));
            end
        end
        key_up = 1'b1;
        step();
        key_up = 1'b0;
        checks++;
        if (dir !== 2'd3) begin
            errors++;
            $display("FAIL dir_before_tick got %0d want 3", dir);
        end
        for (int i = 2; i <= 10; i++) begin
            step();
            checks++;
            if (dir !== ((i == 10) ? 2'd0 : 2'd3) || move_tick !== (i == 10)) begin
                errors++;
                $display("FAIL dir_up_commit_%0d got dir=%0d mt=%0d want dir=%0d mt=%0d",
                         i, dir, move_tick, ((i == 10) ? 0 : 3), (i == 10));
            end
        end
    endtask

    task automatic test_grow();
        for (int k = 1; k <= 4; k++) begin
            add_cube = 1'b1;
            step();
            add_cube = 1'b0;
            checks++;
            if (snake_len !== (((3 + k) > 5) ? 6'd5 : 6'(3 + k)) || score !== 8'(k)) begin
                errors++;
                $display("FAIL grow_%0d got len=%0d score=%0d want len=%0d score=%0d",
                         k, snake_len, score, (((3 + k) > 5) ? 5 : 3 + k), k);
            end
        end
    endtask

    task automatic test_die();
        add_cube = 1'b1;
        hit_body = 1'b1;
        step();
        add_cube = 1'b0;
        hit_body = 1'b0;
        checks++;
        if (game_state !== 2'd3 || snake_len !== 6'd5 || score !== 8'd4 ||
            move_tick !== 1'b0 || flash_en !== 1'b0) begin
            errors++;
            $display("FAIL die_entry got st=%0d len=%0d score=%0d mt=%0d fl=%0d want 3 5 4 0 0",
                     game_state, snake_len, score, move_tick, flash_en);
        end
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) key_start = 1'b1;
            step();
            key_start = 1'b0;
            checks++;
            if (flash_en !== (i >= 10 && i < 20) || game_state !== ((i < 20) ? 2'd3 : 2'd0)) begin
                errors++;
                $display("FAIL die_flash_%0d got fl=%0d st=%0d want fl=%0d st=%0d",
                         i, flash_en, game_state, (i >= 10 && i < 20), ((i < 20) ? 3 : 0));
            end
        end
        checks++;
        if (snake_len !== 6'd5 || score !== 8'd4) begin
            errors++;
            $display("FAIL die_hold got len=%0d score=%0d want 5 4", snake_len, score);
        end
        hit_wall = 1'b1;
        step();
        hit_wall = 1'b0;
        checks++;
        if (game_state !== 2'd0) begin
            errors++;
            $display("FAIL idle_ignores_hit got st=%0d want 0", game_state);
        end
    endtask

    task automatic test_pause();
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        checks++;
        if (game_state !== 2'd1 || snake_len !== 6'd3 || score !== 8'd0 || dir !== 2'd3) begin
            errors++;
            $display("FAIL restart_load got st=%0d len=%0d score=%0d dir=%0d want 1 3 0 3",
                     game_state, snake_len, score, dir);
        end
        for (int i = 0; i < 4; i++) step();
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        checks++;
        if (game_state !== 2'd2 || move_tick !== 1'b0) begin
            errors++;
            $display("FAIL pause_entry got st=%0d mt=%0d want 2 0", game_state, move_tick);
        end
        for (int i = 1; i <= 50; i++) begin
            if (i == 10) begin
                add_cube = 1'b1;
                key_up   = 1'b1;
            end
            if (i == 20) hit_wall = 1'b1;
            step();
            add_cube = 1'b0;
            key_up   = 1'b0;
            hit_wall = 1'b0;
            checks++;
            if (move_tick !== 1'b0 || game_state !== 2'd2) begin
                errors++;
                $display("FAIL pause_hold_%0d got mt=%0d st=%0d want 0 2", i, move_tick, game_state);
            end
        end
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        checks++;
        if (game_state !== 2'd1 || move_tick !== 1'b0) begin
            errors++;
            $display("FAIL resume got st=%0d mt=%0d want 1 0", game_state, move_tick);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (move_tick !== (i == 6)) begin
                errors++;
                $display("FAIL resume_tick_%0d got %0d want %0d", i, move_tick, (i == 6));
            end
        end
        checks++;
        if (dir !== 2'd3 || snake_len !== 6'd3 || score !== 8'd0) begin
            errors++;
            $display("FAIL pause_ignored_inputs got dir=%0d len=%0d score=%0d want 3 3 0",
                     dir, snake_len, score);
        end
    endtask

    task automatic test_priority();
        key_down  = 1'b1;
        key_left  = 1'b1;
        key_right = 1'b1;
        step();
        key_down  = 1'b0;
        key_left  = 1'b0;
        key_right = 1'b0;
        for (int i = 2; i <= 9; i++) step();
        step();
        checks++;
        if (move_tick !== 1'b1 || dir !== 2'd1) begin
            errors++;
            $display("FAIL key_priority got mt=%0d dir=%0d want 1 1", move_tick, dir);
        end
    endtask

    task automatic test_reset_die();
        add_cube = 1'b1;
        step();
        add_cube = 1'b0;
        hit_wall = 1'b1;
        step();
        hit_wall = 1'b0;
        checks++;
        if (game_state !== 2'd3 || snake_len !== 6'd4 || score !== 8'd1) begin
            errors++;
            $display("FAIL die_setup got st=%0d len=%0d score=%0d want 3 4 1", game_state, snake_len, score);
        end
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (flash_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_die_flash got %0d want 1", flash_en);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (game_state !== 2'd0 || move_tick !== 1'b0 || dir !== 2'd3 ||
            snake_len !== 6'd3 || score !== 8'd0 || flash_en !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_die got st=%0d mt=%0d dir=%0d len=%0d score=%0d fl=%0d want 0 0 3 3 0 0",
                     game_state, move_tick, dir, snake_len, score, flash_en);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (game_state !== 2'd0 || flash_en !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_release got st=%0d fl=%0d want 0 0", game_state, flash_en);
        end
    endtask

    initial begin
        test_reset();
        test_start_ticks();
        test_dir_change();
        test_grow();
        test_die();
        test_pause();
        test_priority();
        test_reset_die();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
